// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles; MTHI/MTLO complete in a single cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot, rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !cancel && !md_op[2]) state_d = CALC;
            CALC: begin
                if (cancel) state_d = IDLE;
                else if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;

        signed_op = ~md_op[0];
        a_neg     = signed_op & data1[WIDTH-1];
        b_neg     = signed_op & data2[WIDTH-1];
        a_abs     = a_neg ? -data1 : data1;
        b_abs     = b_neg ? -data2 : data2;

        // Multiply adds into the upper half then shifts right; the low half
        // starts as the multiplier and drains out as product bits arrive.
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        // Divide keeps remainder in the upper half, dividend/quotient in the low half.
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};

        prod_fix  = neg_res_q ? -prod_q : prod_q;
        quot      = prod_q[WIDTH-1:0];
        rem       = prod_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    case (md_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            opnd_d    = md_op[1] ? b_abs : a_abs;
                            prod_d    = {{WIDTH{1'b0}}, (md_op[1] ? a_abs : b_abs)};
                            is_div_d  = md_op[1];
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            cnt_d     = '0;
                        end
                        3'b100:  hi_d = data1;
                        3'b101:  lo_d = data1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (!cancel) begin
                    cnt_d = cnt_q + CW'(1);
                    if (is_div_q)
                        prod_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                                  prod_q[WIDTH-2:0], div_ge};
                    else
                        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                end
            end
            FIN: begin
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Divide-by-zero quotient stays all ones regardless of signs.
                        lo_d = (neg_res_q && opnd_q != '0) ? -quot : quot;
                        hi_d = neg_rem_q ? -rem : rem;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic results, latency, MTHI/MTLO,
// busy-time start masking, cancel and asynchronous reset.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] data1, data2;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op),
        .data1(data1), .data2(data2), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Issue an op at a negedge, then follow it until busy drops (bounded).
    // Returns with the bench sitting on the negedge where done should be high.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int early_dones, output logic done_end);
        start = 1'b1; md_op = op; data1 = a; data2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; early_dones = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (done) early_dones++;
            @(negedge clk);
        end
        done_end = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; md_op = 3'b000; data1 = '0; data2 = '0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int c, ed; logic de;
        run_md(3'b000, 32'hFFFFFFFD, 32'd5, c, ed, de);
        n_cmp++;
        if (c !== 33) begin n_err++; $display("FAIL mult_latency: got %0d cycles, want 33", c); end
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            n_err++; $display("FAIL mult_result: hi=%h lo=%h, want ffffffff fffffff1", hi, lo);
        end
        n_cmp++;
        if (de !== 1'b1 || ed !== 0) begin
            n_err++; $display("FAIL mult_done: done_end=%b early=%0d, want 1 0", de, ed);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse: done=%b, want 0", done); end
    endtask

    task automatic test_multu_ignore_start();
        int cyc = 0; int dones = 0;
        start = 1'b1; md_op = 3'b001; data1 = 32'hFFFFFFFF; data2 = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (busy && cyc < 100) begin
            cyc++;
            if (done) dones++;
            start = (cyc == 5 || cyc == 10);
            md_op = (cyc == 5) ? 3'b100 : 3'b011;
            data1 = 32'hDEADBEEF; data2 = 32'd3;
            @(negedge clk);
            if (cyc == 5) begin
                n_cmp++;
                if (hi !== 32'hFFFFFFFF) begin
                    n_err++; $display("FAIL busy_mthi_ignored: hi=%h, want ffffffff", hi);
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (cyc !== 33 || dones !== 0) begin
            n_err++; $display("FAIL multu_latency: cycles=%0d early=%0d, want 33 0", cyc, dones);
        end
        n_cmp++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || done !== 1'b1) begin
            n_err++; $display("FAIL multu_result: hi=%h lo=%h done=%b, want fffffffe 00000001 1", hi, lo, done);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored: busy=%b, want 0", busy); end
    endtask

    task automatic test_div_back_to_back();
        int c, ed; logic de;
        run_md(3'b010, 32'hFFFFFFF9, 32'd2, c, ed, de);
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || c !== 33 || de !== 1'b1) begin
            n_err++; $display("FAIL div_neg: hi=%h lo=%h cyc=%0d done=%b, want ffffffff fffffffd 33 1", hi, lo, c, de);
        end
        // Next op issued in the done cycle.
        run_md(3'b010, 32'h80000000, 32'hFFFFFFFF, c, ed, de);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h80000000 || c !== 33 || de !== 1'b1) begin
            n_err++; $display("FAIL div_overflow: hi=%h lo=%h cyc=%0d done=%b, want 0 80000000 33 1", hi, lo, c, de);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int c, ed; logic de;
        run_md(3'b011, 32'd7, 32'd0, c, ed, de);
        n_cmp++;
        if (hi !== 32'h7 || lo !== 32'hFFFFFFFF || c !== 33 || de !== 1'b1) begin
            n_err++; $display("FAIL divu_zero: hi=%h lo=%h cyc=%0d done=%b, want 7 ffffffff 33 1", hi, lo, c, de);
        end
        run_md(3'b010, 32'hFFFFFFF9, 32'd0, c, ed, de);
        n_cmp++;
        if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL div_zero_signed: hi=%h lo=%h, want fffffff9 ffffffff", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; md_op = 3'b100; data1 = 32'h12345678;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL mthi: hi=%h busy=%b done=%b, want 12345678 0 0", hi, busy, done);
        end
        md_op = 3'b101; data1 = 32'hCAFEBABE;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (lo !== 32'hCAFEBABE || hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, want 12345678 cafebabe 0 0", hi, lo, busy, done);
        end
        md_op = 3'b110; data1 = 32'h0;
        @(posedge clk); @(negedge clk);
        md_op = 3'b100; cancel = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        n_cmp++;
        if (hi !== 32'h12345678 || lo !== 32'hCAFEBABE || busy !== 1'b0) begin
            n_err++; $display("FAIL reserved_and_cancel_idle: hi=%h lo=%h busy=%b, want 12345678 cafebabe 0", hi, lo, busy);
        end
    endtask

    task automatic test_cancel();
        int dones = 0;
        start = 1'b1; md_op = 3'b000; data1 = 32'd2; data2 = 32'd3;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            if (done) dones++;
            @(negedge clk);
        end
        cancel = 1'b1;
        @(posedge clk); @(negedge clk);
        cancel = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy: busy=%b, want 0", busy); end
        repeat (40) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones !== 0 || hi !== 32'h12345678 || lo !== 32'hCAFEBABE) begin
            n_err++; $display("FAIL cancel_hold: dones=%0d hi=%h lo=%h, want 0 12345678 cafebabe", dones, hi, lo);
        end
    endtask

    task automatic test_async_reset();
        int c, ed; logic de;
        start = 1'b1; md_op = 3'b001; data1 = 32'd16; data2 = 32'd16;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_err++; $display("FAIL async_reset: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_md(3'b001, 32'd6, 32'd7, c, ed, de);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'd42 || c !== 33 || de !== 1'b1) begin
            n_err++; $display("FAIL multu_after_reset: hi=%h lo=%h cyc=%0d done=%b, want 0 2a 33 1", hi, lo, c, de);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_ignore_start();
        test_div_back_to_back();
        test_div_zero();
        test_mthi_mtlo();
        test_cancel();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
